// File: rtl/turret_pkg.sv
// Shared definitions for the turret APB controller: register map, STATUS bits,
// fire sequencer states and default timing.
package turret_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned POS_W  = 16;
   localparam int unsigned TMR_W  = 24;

   localparam logic [ADDR_W-1:0] OFF_CTRL     = 8'h00;
   localparam logic [ADDR_W-1:0] OFF_PAN_TGT  = 8'h04;
   localparam logic [ADDR_W-1:0] OFF_TILT_TGT = 8'h08;
   localparam logic [ADDR_W-1:0] OFF_STATUS   = 8'h0C;
   localparam logic [ADDR_W-1:0] OFF_PAN_CUR  = 8'h10;
   localparam logic [ADDR_W-1:0] OFF_TILT_CUR = 8'h14;

   localparam int unsigned ST_PAN_BUSY  = 0;
   localparam int unsigned ST_TILT_BUSY = 1;
   localparam int unsigned ST_FIRE_ACT  = 2;
   localparam int unsigned ST_COOLDOWN  = 3;
   localparam int unsigned ST_DROPPED   = 4;

   localparam int unsigned DEF_PERIOD_TICKS   = 200000;
   localparam int unsigned DEF_MIN_PW         = 10000;
   localparam int unsigned DEF_MAX_PW         = 20000;
   localparam int unsigned DEF_CENTER_PW      = 15000;
   localparam int unsigned DEF_STEP           = 200;
   localparam int unsigned DEF_FIRE_TICKS     = 500000;
   localparam int unsigned DEF_COOLDOWN_TICKS = 5000000;

   typedef enum logic [1:0] {
      FIRE_IDLE     = 2'd0,
      FIRE_ACTIVE   = 2'd1,
      FIRE_COOLDOWN = 2'd2
   } fire_state_e;

   // Saturate a written target into the legal pulse-width window.
   function automatic logic [POS_W-1:0] clamp_pw(input logic [DATA_W-1:0] v,
                                                 input int unsigned lo,
                                                 input int unsigned hi);
      if (v < DATA_W'(lo))      return POS_W'(lo);
      else if (v > DATA_W'(hi)) return POS_W'(hi);
      else                      return POS_W'(v);
   endfunction

endpackage

// File: rtl/turret_apb_ctrl_servo.sv
// One servo axis: frame-synchronous slew of the current position toward the
// target and the registered PWM compare against the shared frame counter.
module servo_slew_pwm
   import turret_pkg::*;
#(
   parameter int unsigned CNT_W     = 18,
   parameter int unsigned STEP      = DEF_STEP,
   parameter int unsigned CENTER_PW = DEF_CENTER_PW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wrap,
   input  logic             enable,
   input  logic [CNT_W-1:0] count,
   input  logic [POS_W-1:0] tgt,
   output logic [POS_W-1:0] cur,
   output logic             pwm
);

   logic [POS_W-1:0] cur_nxt;

   // Move toward the target by at most STEP without overshooting.
   always_comb begin
      cur_nxt = cur;
      if (tgt > cur)
         cur_nxt = ((tgt - cur) > POS_W'(STEP)) ? cur + POS_W'(STEP) : tgt;
      else if (tgt < cur)
         cur_nxt = ((cur - tgt) > POS_W'(STEP)) ? cur - POS_W'(STEP) : tgt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur <= POS_W'(CENTER_PW);
         pwm <= 1'b0;
      end else begin
         if (wrap) cur <= cur_nxt;
         pwm <= enable & (32'(count) < 32'(cur));
      end
   end

endmodule

// File: rtl/turret_apb_ctrl.sv
// APB3 turret sequencer: target/status registers, shared PWM frame counter,
// two servo channels and the fire solenoid pulse/cooldown sequencer.
module turret_apb_ctrl
   import turret_pkg::*;
#(
   parameter int unsigned PERIOD_TICKS   = DEF_PERIOD_TICKS,
   parameter int unsigned MIN_PW         = DEF_MIN_PW,
   parameter int unsigned MAX_PW         = DEF_MAX_PW,
   parameter int unsigned CENTER_PW      = DEF_CENTER_PW,
   parameter int unsigned STEP           = DEF_STEP,
   parameter int unsigned FIRE_TICKS     = DEF_FIRE_TICKS,
   parameter int unsigned COOLDOWN_TICKS = DEF_COOLDOWN_TICKS
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [DATA_W-1:0] PWDATA,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic              PAN_PWM,
   output logic              TILT_PWM,
   output logic              FIRE,
   output logic              IRQ
);

   localparam int unsigned CNT_W = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;

   logic [ADDR_W-1:0] addr;
   logic              unused_addr_lsb;
   logic              setup, access, addr_err, wr_ok;
   logic              enable, enable_nxt, fire_wr, clr_wr;
   logic [POS_W-1:0]  pan_tgt, tilt_tgt, pan_cur, tilt_cur;
   logic [CNT_W-1:0]  count;
   logic              wrap;
   fire_state_e       state, state_nxt;
   logic [TMR_W-1:0]  timer, timer_nxt;
   logic              fire_nxt, dropped, dropped_nxt;
   logic [DATA_W-1:0] status, rdata;

   assign addr            = {PADDR[ADDR_W-1:2], 2'b00};
   assign unused_addr_lsb = &{1'b0, PADDR[1:0]};
   assign setup           = PSEL & ~PENABLE;
   assign access          = PSEL & PENABLE;
   assign addr_err        = (addr > OFF_TILT_CUR) |
                            (PWRITE & ((addr == OFF_PAN_CUR) | (addr == OFF_TILT_CUR)));
   assign wr_ok           = access & PWRITE & ~addr_err;
   assign enable_nxt      = (wr_ok && addr == OFF_CTRL) ? PWDATA[0] : enable;
   assign fire_wr         = wr_ok & (addr == OFF_CTRL) & PWDATA[1];
   assign clr_wr          = wr_ok & (addr == OFF_STATUS) & PWDATA[ST_DROPPED];
   assign wrap            = enable & (count == CNT_W'(PERIOD_TICKS - 1));
   assign PREADY          = 1'b1;
   assign IRQ             = dropped;

   always_comb begin
      status               = '0;
      status[ST_PAN_BUSY]  = (pan_cur != pan_tgt);
      status[ST_TILT_BUSY] = (tilt_cur != tilt_tgt);
      status[ST_FIRE_ACT]  = (state == FIRE_ACTIVE);
      status[ST_COOLDOWN]  = (state == FIRE_COOLDOWN);
      status[ST_DROPPED]   = dropped;
   end

   always_comb begin
      rdata = '0;
      case (addr)
         OFF_CTRL:     rdata = DATA_W'(enable);
         OFF_PAN_TGT:  rdata = DATA_W'(pan_tgt);
         OFF_TILT_TGT: rdata = DATA_W'(tilt_tgt);
         OFF_STATUS:   rdata = status;
         OFF_PAN_CUR:  rdata = DATA_W'(pan_cur);
         OFF_TILT_CUR: rdata = DATA_W'(tilt_cur);
         default:      rdata = '0;
      endcase
   end

   // Bus-facing registers; read data and error are captured in the setup phase.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         PRDATA   <= '0;
         PSLVERR  <= 1'b0;
         enable   <= 1'b0;
         pan_tgt  <= POS_W'(CENTER_PW);
         tilt_tgt <= POS_W'(CENTER_PW);
      end else begin
         if (setup)        PSLVERR <= addr_err;
         else if (!access) PSLVERR <= 1'b0;
         if (setup && !PWRITE) PRDATA <= rdata;
         enable <= enable_nxt;
         if (wr_ok && addr == OFF_PAN_TGT)  pan_tgt  <= clamp_pw(PWDATA, MIN_PW, MAX_PW);
         if (wr_ok && addr == OFF_TILT_TGT) tilt_tgt <= clamp_pw(PWDATA, MIN_PW, MAX_PW);
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET)               count <= '0;
      else if (!enable || wrap) count <= '0;
      else                      count <= count + CNT_W'(1);
   end

   servo_slew_pwm #(.CNT_W(CNT_W), .STEP(STEP), .CENTER_PW(CENTER_PW)) u_pan (
      .clk(PCLK), .rst(PRESET), .wrap(wrap), .enable(enable),
      .count(count), .tgt(pan_tgt), .cur(pan_cur), .pwm(PAN_PWM)
   );

   servo_slew_pwm #(.CNT_W(CNT_W), .STEP(STEP), .CENTER_PW(CENTER_PW)) u_tilt (
      .clk(PCLK), .rst(PRESET), .wrap(wrap), .enable(enable),
      .count(count), .tgt(tilt_tgt), .cur(tilt_cur), .pwm(TILT_PWM)
   );

   // Fire sequencer; a rejected fire request sets dropped after any W1C clear.
   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer;
      fire_nxt    = 1'b0;
      dropped_nxt = dropped;
      if (clr_wr) dropped_nxt = 1'b0;
      case (state)
         FIRE_IDLE: begin
            if (fire_wr && enable_nxt) begin
               state_nxt = FIRE_ACTIVE;
               timer_nxt = TMR_W'(FIRE_TICKS - 1);
               fire_nxt  = 1'b1;
            end else if (fire_wr) begin
               dropped_nxt = 1'b1;
            end
         end
         FIRE_ACTIVE: begin
            if (fire_wr) dropped_nxt = 1'b1;
            if (!enable_nxt || timer == '0) begin
               state_nxt = FIRE_COOLDOWN;
               timer_nxt = TMR_W'(COOLDOWN_TICKS - 1);
            end else begin
               timer_nxt = timer - TMR_W'(1);
               fire_nxt  = 1'b1;
            end
         end
         FIRE_COOLDOWN: begin
            if (fire_wr) dropped_nxt = 1'b1;
            if (timer == '0) state_nxt = FIRE_IDLE;
            else             timer_nxt = timer - TMR_W'(1);
         end
         default: state_nxt = FIRE_IDLE;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state   <= FIRE_IDLE;
         timer   <= '0;
         FIRE    <= 1'b0;
         dropped <= 1'b0;
      end else begin
         state   <= state_nxt;
         timer   <= timer_nxt;
         FIRE    <= fire_nxt;
         dropped <= dropped_nxt;
      end
   end

endmodule

// File: doc/turret_apb_ctrl.md
Name: turret_apb_ctrl

Overview:
- APB3 slave on the MSS fabric APB bus (MSSPSEL/MSSPENABLE/... side) that sequences the turret actuators.
- Holds pan/tilt target registers and slews the current servo positions toward the targets, at most one step per PWM frame.
- Generates the two servo PWM outputs.
- Schedules the fire solenoid pulse with an enforced cooldown.

Parameters:
- PERIOD_TICKS, 200000, PWM frame length in PCLK cycles (20 ms at 10 MHz).
- MIN_PW, 10000, minimum pulse width in ticks (1.0 ms).
- MAX_PW, 20000, maximum pulse width in ticks (2.0 ms).
- CENTER_PW, 15000, reset pulse width for both axes.
- STEP, 200, maximum change of the current position per frame.
- FIRE_TICKS, 500000, solenoid on-time (50 ms).
- COOLDOWN_TICKS, 5000000, minimum gap after the fire pulse ends (500 ms).

Ports:
- PCLK  in  1  fabric clock (FAB_CLK).
- PRESET  in  1  asynchronous reset, active-high.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  APB write.
- PADDR  in  8  byte address; [1:0] ignored.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  always 1.
- PSLVERR  out  1  error response.
- PAN_PWM  out  1  pan servo PWM.
- TILT_PWM  out  1  tilt servo PWM.
- FIRE  out  1  solenoid drive.
- IRQ  out  1  level interrupt, high while STATUS.dropped = 1.

Behaviour:
- Reset values: PRDATA=0, PSLVERR=0, PAN_PWM=TILT_PWM=FIRE=IRQ=0. Targets and currents = CENTER_PW. Frame counter=0. CTRL.enable=0. Fire FSM in IDLE.
- Register map (32-bit, unused bits read 0):
  - 0x00 CTRL RW: [0] enable; [1] fire, write-1 pulse, reads 0.
  - 0x04 PAN_TGT RW [15:0].
  - 0x08 TILT_TGT RW [15:0].
  - 0x0C STATUS: [0] pan_busy (cur≠tgt); [1] tilt_busy; [2] fire_active; [3] cooldown; [4] dropped, sticky, write-1-to-clear.
  - 0x10 PAN_CUR RO.
  - 0x14 TILT_CUR RO.
- APB, zero wait state:
  - Write commits on the PCLK edge where PSEL & PENABLE & PWRITE.
  - PRDATA is registered in the setup phase (PSEL & !PENABLE & !PWRITE) and held through the access phase.
  - PSLVERR=1 during the access phase for an address >0x14, or a write to a RO address (0x10/0x14). The register state is then unchanged.
- Target writes are clamped: value <MIN_PW stores MIN_PW; value >MAX_PW stores MAX_PW. No error is raised.
- Frame counter:
  - While enable=1, counts 0..PERIOD_TICKS-1 and wraps.
  - While enable=0, counter is held at 0, both PWM outputs are low, and currents are frozen.
  - When enable rises, the counter restarts from 0.
- PWM: PAN_PWM = enable & (counter < PAN_CUR), registered (1-cycle latency). Same rule for tilt.
- Slew: on the cycle the counter wraps to 0, each current moves toward its target by min(STEP, |tgt−cur|). Currents are only updated at frame start, so a pulse is never truncated mid-frame.
- A target write in the same cycle as the wrap takes effect at the next frame; the slew uses the old target.
- Fire FSM, states IDLE → ACTIVE → COOLDOWN → IDLE:
  - IDLE: a fire write with enable=1 enters ACTIVE. FIRE=1 from the next cycle for exactly FIRE_TICKS cycles.
  - ACTIVE: after FIRE_TICKS cycles, go to COOLDOWN, FIRE=0, for COOLDOWN_TICKS cycles, then IDLE.
  - A fire write in ACTIVE or COOLDOWN, or with enable=0, is ignored and sets dropped.
  - A fire write together with a W1C of dropped in the same cycle: the set wins.
- enable cleared mid-fire: FIRE drops to 0 on the next cycle and the FSM goes to COOLDOWN. Cooldown is never skipped.
- PRESET mid-operation returns everything to reset values immediately, asynchronously. FIRE goes low immediately.
- Timer: one shared 24-bit down-counter serves both ACTIVE and COOLDOWN.

Decomposition:
- Package turret_pkg: register offsets, STATUS bit indices, fire FSM state enum, default timing constants.
- Sub-module servo_slew_pwm, instantiated twice (pan, tilt). It takes the frame counter, the wrap strobe, enable and target, and produces the current position and PWM. The frame counter is shared in the top.

Test Plan:
- Reset, then read 0x04/0x10 → 15000 (0x3A98). Read 0x0C → 0. All outputs 0.
- Write PAN_TGT=16000, enable=1 (PERIOD_TICKS reduced to 1000 with scaled widths in the bench) → PAN_CUR steps +STEP each frame until equal. pan_busy then clears. PAN_PWM high-time per frame equals PAN_CUR.
- Write TILT_TGT=5 → reads back MIN_PW. Write 0x10 → PSLVERR=1 and PAN_CUR unchanged. Read 0x20 → PSLVERR=1.
- Fire write (enable=1) → FIRE high exactly FIRE_TICKS cycles. A second fire during cooldown → FIRE stays 0, dropped=1, IRQ=1. W1C of 0x10 to STATUS → IRQ=0.
- Clear enable during ACTIVE → FIRE=0 next cycle, cooldown=1 for COOLDOWN_TICKS. Both PWM outputs low.
- Assert PRESET mid-frame with FIRE=1 → FIRE and both PWM outputs 0 immediately, currents back to CENTER_PW.
